// File: rtl/snake_pkg.sv
// Shared Snake grid geometry, coordinate type and spawn FSM state encoding.
package snake_pkg;

  localparam int unsigned GRID_W    = 40;
  localparam int unsigned GRID_H    = 30;
  localparam int unsigned COORD_W   = 6;
  localparam int unsigned MAX_TRIES = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    SEED,
    IDLE,
    DRAW_X,
    DRAW_Y,
    CHECK,
    WAIT,
    SCAN,
    SCAN_WAIT
  } state_t;

  // Unsigned v < lim, evaluated one bit wider so a 64-wide grid accepts every code.
  function automatic logic in_range(coord_t v, int unsigned lim);
    logic [COORD_W:0] l;
    l = lim[COORD_W:0];
    return {1'b0, v} < l;
  endfunction

endpackage

// File: rtl/food_spawn_ctrl_if.sv
// Signal bundle between the food spawner and its requester, PRNG and occupancy RAM.
// master: the spawn controller; slave: the surrounding game logic.
interface food_spawn_ctrl_if import snake_pkg::*; ();

  logic   spawn_req;
  logic   spawn_busy;
  logic   prng_load;
  coord_t prng_num;
  logic   occ_req;
  coord_t occ_x;
  coord_t occ_y;
  logic   occ_hit;
  coord_t food_x;
  coord_t food_y;
  logic   food_valid;
  logic   spawn_fail;

  modport master (
    input  spawn_req, prng_num, occ_hit,
    output spawn_busy, prng_load, occ_req, occ_x, occ_y,
           food_x, food_y, food_valid, spawn_fail
  );

  modport slave (
    output spawn_req, prng_num, occ_hit,
    input  spawn_busy, prng_load, occ_req, occ_x, occ_y,
           food_x, food_y, food_valid, spawn_fail
  );

endinterface

// File: rtl/grid_xy_counter.sv
// Row-major X/Y walker over the grid, used for the exhaustive free-cell scan.
module grid_xy_counter #(
  parameter int unsigned GRID_W = snake_pkg::GRID_W,
  parameter int unsigned GRID_H = snake_pkg::GRID_H
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output snake_pkg::coord_t x,
  output snake_pkg::coord_t y,
  output snake_pkg::coord_t nx,
  output snake_pkg::coord_t ny,
  output logic last
);
  import snake_pkg::*;

  localparam coord_t X_LAST = coord_t'(GRID_W - 1);
  localparam coord_t Y_LAST = coord_t'(GRID_H - 1);

  // Position the walk moves to on the next increment; X wraps into the next row.
  always_comb begin
    nx = x;
    ny = y;
    if (x == X_LAST) begin
      nx = '0;
      ny = (y == Y_LAST) ? '0 : y + 1'b1;
    end else begin
      nx = x + 1'b1;
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Current walk position; clear restarts at the top-left cell.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      x <= nx;
      y <= ny;
    end
  end

endmodule

// File: rtl/food_spawn_ctrl.sv
// Places a new food item: random X/Y draws from the PRNG with range and occupancy
// rejection, falling back to a row-major scan after MAX_TRIES rejections.
module food_spawn_ctrl #(
  parameter int unsigned GRID_W    = snake_pkg::GRID_W,
  parameter int unsigned GRID_H    = snake_pkg::GRID_H,
  parameter int unsigned MAX_TRIES = snake_pkg::MAX_TRIES
) (
  input logic               clk,
  input logic               rst,
  food_spawn_ctrl_if.master bus
);
  import snake_pkg::*;

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

  state_t           state;
  logic [TRY_W-1:0] tries;
  coord_t           cand_x, cand_y;
  coord_t           occ_x, occ_y, food_x, food_y;
  logic             busy, load, occ_req, food_valid, spawn_fail;

  logic   x_ok, y_ok, reject, tries_last, scan_clr, scan_inc, scan_last;
  coord_t scan_x, scan_y, scan_nx, scan_ny;

  grid_xy_counter #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clr  (scan_clr),
    .inc  (scan_inc),
    .x    (scan_x),
    .y    (scan_y),
    .nx   (scan_nx),
    .ny   (scan_ny),
    .last (scan_last)
  );

  // Per-cycle rejection decision and scan-walker control.
  always_comb begin
    x_ok       = in_range(bus.prng_num, GRID_W);
    y_ok       = in_range(bus.prng_num, GRID_H);
    reject     = ((state == DRAW_X) && !x_ok) ||
                 ((state == DRAW_Y) && !y_ok) ||
                 ((state == WAIT) && bus.occ_hit);
    tries_last = (tries == TRY_LAST);
    scan_clr   = reject && tries_last;
    scan_inc   = (state == SCAN_WAIT) && bus.occ_hit && !scan_last;
  end

  // Spawn sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEED;
      tries      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      busy       <= 1'b0;
      load       <= 1'b0;
      occ_req    <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      spawn_fail <= 1'b0;
    end else begin
      load       <= 1'b0;
      occ_req    <= 1'b0;
      food_valid <= 1'b0;
      spawn_fail <= 1'b0;
      unique case (state)
        SEED: begin
          load  <= 1'b1;
          busy  <= 1'b1;
          state <= IDLE;
        end
        IDLE: begin
          busy <= 1'b0;
          if (bus.spawn_req) begin
            busy  <= 1'b1;
            tries <= '0;
            state <= DRAW_X;
          end
        end
        DRAW_X: begin
          cand_x <= bus.prng_num;
          if (x_ok) state <= DRAW_Y;
        end
        DRAW_Y: begin
          cand_y <= bus.prng_num;
          if (y_ok) begin
            occ_req <= 1'b1;
            occ_x   <= cand_x;
            occ_y   <= bus.prng_num;
            state   <= CHECK;
          end
        end
        CHECK: state <= WAIT;
        WAIT: begin
          if (!bus.occ_hit) begin
            food_x     <= cand_x;
            food_y     <= cand_y;
            food_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            state <= DRAW_X;
          end
        end
        SCAN: state <= SCAN_WAIT;
        SCAN_WAIT: begin
          if (!bus.occ_hit) begin
            food_x     <= scan_x;
            food_y     <= scan_y;
            food_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (scan_last) begin
            spawn_fail <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            occ_req <= 1'b1;
            occ_x   <= scan_nx;
            occ_y   <= scan_ny;
            state   <= SCAN;
          end
        end
        default: state <= SEED;
      endcase
      // Every rejection is tallied here, after the case, so the final one can
      // override the per-state next state and divert into the scan.
      if (reject) begin
        if (tries_last) begin
          tries   <= TRY_MAX;
          occ_req <= 1'b1;
          occ_x   <= '0;
          occ_y   <= '0;
          state   <= SCAN;
        end else begin
          tries <= tries + 1'b1;
        end
      end
    end
  end

  assign bus.spawn_busy = busy;
  assign bus.prng_load  = load;
  assign bus.occ_req    = occ_req;
  assign bus.occ_x      = occ_x;
  assign bus.occ_y      = occ_y;
  assign bus.food_x     = food_x;
  assign bus.food_y     = food_y;
  assign bus.food_valid = food_valid;
  assign bus.spawn_fail = spawn_fail;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Bench for food_spawn_ctrl: cycle table on a default 40x30 instance, hand
// sequences for fallback, full board and mid-scan reset on a 4x2 instance.
module tb_food_spawn_ctrl;

  typedef struct packed {
    logic       busy;
    logic       load;
    logic       oreq;
    logic [5:0] ox;
    logic [5:0] oy;
    logic       fv;
    logic [5:0] fx;
    logic [5:0] fy;
    logic       fail;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic [5:0] prng;
    logic       hit;
    out_t       exp;
  } vec_t;

  localparam int NV = 28;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  food_spawn_ctrl_if ifa ();
  food_spawn_ctrl_if ifb ();

  food_spawn_ctrl dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  food_spawn_ctrl #(
    .GRID_W    (4),
    .GRID_H    (2),
    .MAX_TRIES (4)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  function automatic vec_t mk(input int r, q, p, h, b, l, o, x, y, v, fx, fy, f);
    vec_t t;
    t.rst      = 1'(r);
    t.req      = 1'(q);
    t.prng     = 6'(p);
    t.hit      = 1'(h);
    t.exp.busy = 1'(b);
    t.exp.load = 1'(l);
    t.exp.oreq = 1'(o);
    t.exp.ox   = 6'(x);
    t.exp.oy   = 6'(y);
    t.exp.fv   = 1'(v);
    t.exp.fx   = 6'(fx);
    t.exp.fy   = 6'(fy);
    t.exp.fail = 1'(f);
    return t;
  endfunction

  function automatic out_t get_a();
    out_t o;
    o.busy = ifa.spawn_busy;
    o.load = ifa.prng_load;
    o.oreq = ifa.occ_req;
    o.ox   = ifa.occ_x;
    o.oy   = ifa.occ_y;
    o.fv   = ifa.food_valid;
    o.fx   = ifa.food_x;
    o.fy   = ifa.food_y;
    o.fail = ifa.spawn_fail;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_b(input int req, input int prng, input int hit);
    ifb.spawn_req = 1'(req);
    ifb.prng_num  = 6'(prng);
    ifb.occ_hit   = 1'(hit);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b_food(input string tag, input int fv, input int fail, input int fx, input int fy);
    chk({tag, "_fv"},   32'(ifb.food_valid), 32'(fv));
    chk({tag, "_fail"}, 32'(ifb.spawn_fail), 32'(fail));
    chk({tag, "_fx"},   32'(ifb.food_x),     32'(fx));
    chk({tag, "_fy"},   32'(ifb.food_y),     32'(fy));
  endtask

  initial begin
    ifa.spawn_req = 1'b0; ifa.prng_num = '0; ifa.occ_hit = 1'b0;
    ifb.spawn_req = 1'b0; ifb.prng_num = '0; ifb.occ_hit = 1'b0;

    //              rst req prng hit | busy load oreq ox oy fv fx fy fail
    tbl[0]  = mk(1, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(1, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[2]  = mk(0, 0,  0, 0,  1, 1, 0,  0, 0, 0,  0, 0, 0);
    tbl[3]  = mk(0, 0,  0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
    // happy path: request, x=12, y=7, free
    tbl[4]  = mk(0, 1,  0, 0,  1, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[5]  = mk(0, 0, 12, 0,  1, 0, 0,  0, 0, 0,  0, 0, 0);
    tbl[6]  = mk(0, 0,  7, 0,  1, 0, 1, 12, 7, 0,  0, 0, 0);
    tbl[7]  = mk(0, 0, 50, 1,  1, 0, 0, 12, 7, 0,  0, 0, 0);
    tbl[8]  = mk(0, 0,  0, 0,  0, 0, 0, 12, 7, 1, 12, 7, 0);
    tbl[9]  = mk(0, 0,  0, 0,  0, 0, 0, 12, 7, 0, 12, 7, 0);
    // range rejects: 45 (x), 12, 31 (y), 7
    tbl[10] = mk(0, 1,  0, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[11] = mk(0, 0, 45, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[12] = mk(0, 0, 12, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[13] = mk(0, 0, 31, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[14] = mk(0, 0,  7, 0,  1, 0, 1, 12, 7, 0, 12, 7, 0);
    tbl[15] = mk(0, 0,  0, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[16] = mk(0, 0,  0, 0,  0, 0, 0, 12, 7, 1, 12, 7, 0);
    tbl[17] = mk(0, 0,  0, 0,  0, 0, 0, 12, 7, 0, 12, 7, 0);
    // occupied (12,7), then free (3,4); requests while busy are dropped
    tbl[18] = mk(0, 1,  0, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[19] = mk(0, 1, 12, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[20] = mk(0, 0,  7, 0,  1, 0, 1, 12, 7, 0, 12, 7, 0);
    tbl[21] = mk(0, 0,  0, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[22] = mk(0, 0,  0, 1,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[23] = mk(0, 1,  3, 0,  1, 0, 0, 12, 7, 0, 12, 7, 0);
    tbl[24] = mk(0, 0,  4, 0,  1, 0, 1,  3, 4, 0, 12, 7, 0);
    tbl[25] = mk(0, 0,  0, 0,  1, 0, 0,  3, 4, 0, 12, 7, 0);
    tbl[26] = mk(0, 0,  0, 0,  0, 0, 0,  3, 4, 1,  3, 4, 0);
    tbl[27] = mk(0, 0,  0, 0,  0, 0, 0,  3, 4, 0,  3, 4, 0);

    for (int i = 0; i < NV; i++) begin
      rst_a         = tbl[i].rst;
      ifa.spawn_req = tbl[i].req;
      ifa.prng_num  = tbl[i].prng;
      ifa.occ_hit   = tbl[i].hit;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 32'(get_a()), 32'(tbl[i].exp));
    end

    // --- 4x2 instance, MAX_TRIES=4: reset state and seed pulse
    chk("b_rst_busy", 32'(ifb.spawn_busy), 0);
    chk("b_rst_load", 32'(ifb.prng_load), 0);
    chk("b_rst_oreq", 32'(ifb.occ_req), 0);
    chk_b_food("b_rst", 0, 0, 0, 0);
    rst_b = 1'b0;
    step_b(0, 0, 0);
    chk("b_seed_load", 32'(ifb.prng_load), 1);
    chk("b_seed_busy", 32'(ifb.spawn_busy), 1);
    step_b(0, 0, 0);
    chk("b_idle_load", 32'(ifb.prng_load), 0);
    chk("b_idle_busy", 32'(ifb.spawn_busy), 0);

    // --- fallback: every random candidate rejected, scan finds (2,0)
    step_b(1, 0, 0);
    step_b(0, 1, 0);
    step_b(0, 3, 0);
    step_b(0, 0, 0);
    chk("fb_q1_req", 32'(ifb.occ_req), 1);
    chk("fb_q1_x",   32'(ifb.occ_x), 1);
    chk("fb_q1_y",   32'(ifb.occ_y), 0);
    step_b(0, 0, 0);
    step_b(0, 0, 1);
    step_b(0, 2, 0);
    step_b(0, 1, 0);
    chk("fb_q2_x", 32'(ifb.occ_x), 2);
    chk("fb_q2_y", 32'(ifb.occ_y), 1);
    step_b(0, 0, 0);
    step_b(0, 0, 1);
    step_b(0, 9, 0);
    chk("fb_s0_req", 32'(ifb.occ_req), 1);
    chk("fb_s0_x",   32'(ifb.occ_x), 0);
    chk("fb_s0_y",   32'(ifb.occ_y), 0);
    step_b(0, 0, 0);
    chk("fb_s0_wait", 32'(ifb.occ_req), 0);
    step_b(0, 0, 1);
    chk("fb_s1_x", 32'(ifb.occ_x), 1);
    step_b(0, 0, 0);
    step_b(0, 0, 1);
    chk("fb_s2_x", 32'(ifb.occ_x), 2);
    chk("fb_s2_y", 32'(ifb.occ_y), 0);
    step_b(0, 0, 0);
    chk_b_food("fb_pre", 0, 0, 0, 0);
    step_b(0, 0, 0);
    chk_b_food("fb_done", 1, 0, 2, 0);
    chk("fb_done_busy", 32'(ifb.spawn_busy), 0);
    step_b(0, 0, 0);
    chk_b_food("fb_after", 0, 0, 2, 0);

    // --- full board: four range rejects force the scan, all 8 cells hit
    step_b(1, 0, 0);
    for (int r = 0; r < 4; r++) step_b(0, 63, 0);
    for (int q = 0; q < 8; q++) begin
      chk($sformatf("full_q%0d_req", q), 32'(ifb.occ_req), 1);
      chk($sformatf("full_q%0d_x", q),   32'(ifb.occ_x), 32'(q % 4));
      chk($sformatf("full_q%0d_y", q),   32'(ifb.occ_y), 32'(q / 4));
      step_b(0, 0, 0);
      chk($sformatf("full_q%0d_wait", q), 32'(ifb.occ_req), 0);
      step_b(0, 0, 1);
    end
    chk_b_food("full_end", 0, 1, 2, 0);
    chk("full_end_busy", 32'(ifb.spawn_busy), 0);
    chk("full_end_req",  32'(ifb.occ_req), 0);
    step_b(0, 0, 0);
    chk_b_food("full_after", 0, 0, 2, 0);

    // --- reset in the middle of a scan
    step_b(1, 0, 0);
    for (int r = 0; r < 4; r++) step_b(0, 63, 0);
    step_b(0, 0, 0);
    step_b(0, 0, 1);
    chk("mid_s1_x", 32'(ifb.occ_x), 1);
    rst_b = 1'b1;
    step_b(0, 0, 1);
    chk("mid_rst_busy", 32'(ifb.spawn_busy), 0);
    chk("mid_rst_oreq", 32'(ifb.occ_req), 0);
    chk("mid_rst_ox",   32'(ifb.occ_x), 0);
    chk_b_food("mid_rst", 0, 0, 0, 0);
    rst_b = 1'b0;
    step_b(0, 0, 0);
    chk("mid_seed_load", 32'(ifb.prng_load), 1);
    chk_b_food("mid_seed", 0, 0, 0, 0);
    step_b(0, 0, 0);
    chk("mid_idle_load", 32'(ifb.prng_load), 0);
    chk("mid_idle_busy", 32'(ifb.spawn_busy), 0);
    chk_b_food("mid_idle", 0, 0, 0, 0);
    step_b(1, 0, 0);
    chk("mid_accept_busy", 32'(ifb.spawn_busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
